toll_collector: RTL and testbench

- Sequential stage directly downstream of the toll-rate SOP logic.
- Consumes that stage's one-hot-ish rate outputs H/M/L/E when a vehicle arrives and latches the fee.
- Accumulates coin credit, returns change, raises the gate, and flags errors and unpaid departures.
- Keeps a running revenue total for the booth.

---
 rtl/toll_collector.sv | 214 +++++++++++++++++++++
 tb/tb_toll_collector.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toll_collector.sv
// -----------------------------------------------------------------------------
// toll_collector
//
// Sequential booth controller that sits directly after the toll-rate logic.
// When a vehicle arrives it latches the fee chosen by the rate selects. It then
// accumulates coin credit, pays out change and raises the gate. It flags rate
// errors, payment timeouts and unpaid departures, and it keeps a saturating
// revenue total for the booth.
//
// Parameters:
//   FEE_H, FEE_M, FEE_L : fee in cents for the high / medium / low rate
//   TIMEOUT             : COLLECT cycles allowed without a coin
//   TW                  : timeout counter width (TIMEOUT < 2**TW)
//
// Ports:
//   CLK         in   clock, all state changes on the rising edge
//   RST         in   synchronous active-high reset
//   H, M, L     in   rate selects from the rate logic (sampled only in IDLE)
//   E           in   rate-logic error flag
//   CAR         in   vehicle present (level)
//   COIN        in   one-cycle coin strobe
//   COIN_VAL    in   [1:0] coin code: 0=5, 1=10, 2=25, 3=100 cents
//   GATE_OPEN   out  gate raised
//   CHANGE      out  [7:0] change / refund in cents, qualified by CHANGE_VLD
//   CHANGE_VLD  out  one-cycle strobe qualifying CHANGE
//   REJECT      out  one-cycle strobe: coin returned (arrived outside COLLECT)
//   ALARM       out  booth fault indicator
//   VIOLATION   out  one-cycle strobe: unpaid departure or payment timeout
//   BUSY        out  high in any state other than IDLE
//   REVENUE     out  [15:0] fees collected since reset, saturating
// -----------------------------------------------------------------------------
module toll_collector #(
    parameter int unsigned FEE_H   = 100,
    parameter int unsigned FEE_M   = 50,
    parameter int unsigned FEE_L   = 25,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned TW      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        H,
    input  logic        M,
    input  logic        L,
    input  logic        E,
    input  logic        CAR,
    input  logic        COIN,
    input  logic [1:0]  COIN_VAL,
    output logic        GATE_OPEN,
    output logic [7:0]  CHANGE,
    output logic        CHANGE_VLD,
    output logic        REJECT,
    output logic        ALARM,
    output logic        VIOLATION,
    output logic        BUSY,
    output logic [15:0] REVENUE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_OPEN,
        S_FAULT
    } state_t;

    localparam logic [7:0]    FEE_H_C    = 8'(FEE_H);
    localparam logic [7:0]    FEE_M_C    = 8'(FEE_M);
    localparam logic [7:0]    FEE_L_C    = 8'(FEE_L);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [7:0]    credit;
    logic [7:0]    fee;
    logic [TW-1:0] timer;
    logic          car_q;       // previous CAR, for rising-edge detection

    logic [7:0]    coin_cents;
    logic [8:0]    sum_wide;
    logic [7:0]    sum_sat;     // credit + current coin, clamped to 255
    logic [7:0]    refund_amt;  // what goes back if the car leaves now
    logic [16:0]   rev_wide;
    logic [15:0]   rev_sat;
    logic          car_rise;
    logic          rate_bad;
    logic [7:0]    rate_fee;

    always_comb begin
        case (COIN_VAL)
            2'd0:    coin_cents = 8'd5;
            2'd1:    coin_cents = 8'd10;
            2'd2:    coin_cents = 8'd25;
            default: coin_cents = 8'd100;
        endcase
    end

    assign sum_wide   = {1'b0, credit} + {1'b0, coin_cents};
    assign sum_sat    = sum_wide[8] ? 8'hFF : sum_wide[7:0];
    // A coin landing in the same cycle the car leaves is refunded, not kept.
    assign refund_amt = COIN ? sum_sat : credit;
    assign rev_wide   = {1'b0, REVENUE} + {9'b0, fee};
    assign rev_sat    = rev_wide[16] ? 16'hFFFF : rev_wide[15:0];
    assign car_rise   = CAR && !car_q;
    assign rate_bad   = E || !(H || M || L);

    // Fee priority H > M > L; E is handled separately by rate_bad.
    always_comb begin
        if (H)      rate_fee = FEE_H_C;
        else if (M) rate_fee = FEE_M_C;
        else        rate_fee = FEE_L_C;
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every right-hand side reads the pre-edge value, whatever the order of
    // statements in this block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            credit     <= '0;
            fee        <= '0;
            timer      <= '0;
            car_q      <= 1'b0;
            GATE_OPEN  <= 1'b0;
            CHANGE     <= '0;
            CHANGE_VLD <= 1'b0;
            REJECT     <= 1'b0;
            ALARM      <= 1'b0;
            VIOLATION  <= 1'b0;
            BUSY       <= 1'b0;
            REVENUE    <= '0;
        end else begin
            car_q      <= CAR;
            // NOTE: the strobes are defaulted low here and raised only by the
            // branch that fires, so each lasts exactly one cycle.
            CHANGE     <= '0;
            CHANGE_VLD <= 1'b0;
            REJECT     <= 1'b0;
            VIOLATION  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (COIN) REJECT <= 1'b1;
                    if (car_rise) begin
                        credit <= '0;
                        timer  <= '0;
                        BUSY   <= 1'b1;
                        if (rate_bad) begin
                            state <= S_FAULT;
                            ALARM <= 1'b1;
                        end else begin
                            fee   <= rate_fee;
                            state <= S_COLLECT;
                        end
                    end
                end

                S_COLLECT: begin
                    if (!CAR) begin
                        // Unpaid departure: hand back everything.
                        CHANGE     <= refund_amt;
                        CHANGE_VLD <= (refund_amt != 8'd0);
                        VIOLATION  <= 1'b1;
                        credit     <= '0;
                        BUSY       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (COIN) begin
                        timer <= '0;
                        if (sum_sat >= fee) begin
                            // Strobe even for exact payment (CHANGE = 0).
                            CHANGE     <= sum_sat - fee;
                            CHANGE_VLD <= 1'b1;
                            REVENUE    <= rev_sat;
                            credit     <= '0;
                            GATE_OPEN  <= 1'b1;
                            state      <= S_OPEN;
                        end else begin
                            credit <= sum_sat;
                        end
                    end else if (timer == TIMER_LAST) begin
                        CHANGE     <= credit;
                        CHANGE_VLD <= (credit != 8'd0);
                        VIOLATION  <= 1'b1;
                        credit     <= '0;
                        ALARM      <= 1'b1;
                        state      <= S_FAULT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                S_OPEN: begin
                    if (COIN) REJECT <= 1'b1;
                    if (!CAR) begin
                        GATE_OPEN <= 1'b0;
                        BUSY      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                S_FAULT: begin
                    if (COIN) REJECT <= 1'b1;
                    if (!CAR) begin
                        ALARM <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toll_collector.sv
// -----------------------------------------------------------------------------
// tb_toll_collector
//
// Randomised and directed vehicle transactions against toll_collector. The
// driver works one vehicle at a time and computes that vehicle's outcome from
// the booth rules: fee, running credit, change, refund and revenue. Every
// strobe the booth should emit is pushed onto a queue. An independent monitor
// pops one entry each time the DUT raises CHANGE_VLD, VIOLATION or REJECT.
// -----------------------------------------------------------------------------
module tb_toll_collector;

    localparam int FEE_H   = 100;
    localparam int FEE_M   = 50;
    localparam int FEE_L   = 25;
    localparam int TIMEOUT = 200;

    logic        CLK = 1'b0;
    logic        RST;
    logic        H, M, L, E, CAR, COIN;
    logic [1:0]  COIN_VAL;
    logic        GATE_OPEN, CHANGE_VLD, REJECT, ALARM, VIOLATION, BUSY;
    logic [7:0]  CHANGE;
    logic [15:0] REVENUE;

    toll_collector #(
        .FEE_H(FEE_H), .FEE_M(FEE_M), .FEE_L(FEE_L),
        .TIMEOUT(TIMEOUT), .TW(8)
    ) dut (
        .CLK(CLK), .RST(RST),
        .H(H), .M(M), .L(L), .E(E),
        .CAR(CAR), .COIN(COIN), .COIN_VAL(COIN_VAL),
        .GATE_OPEN(GATE_OPEN), .CHANGE(CHANGE), .CHANGE_VLD(CHANGE_VLD),
        .REJECT(REJECT), .ALARM(ALARM), .VIOLATION(VIOLATION),
        .BUSY(BUSY), .REVENUE(REVENUE)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        bit vld;
        int change;
        bit viol;
        bit rej;
        int rev;
    } evt_t;

    evt_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   model_rev = 0;
    int   coin_q[$];   // coin codes for the next vehicle
    int   gap_q[$];    // idle COLLECT cycles before each coin

    function automatic int cents(input int code);
        case (code)
            0:       return 5;
            1:       return 10;
            2:       return 25;
            default: return 100;
        endcase
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        COIN = 1'b0;
    endtask

    task automatic expect_reject();
        evt_t ev;
        ev.vld = 1'b0; ev.change = 0; ev.viol = 1'b0; ev.rej = 1'b1; ev.rev = model_rev;
        exp_q.push_back(ev);
    endtask

    task automatic expect_settle(input bit viol, input int amount, input bit force_vld);
        evt_t ev;
        ev.vld = force_vld || (amount > 0); ev.change = amount;
        ev.viol = viol; ev.rej = 1'b0; ev.rev = model_rev;
        exp_q.push_back(ev);
    endtask

    // Monitor: one expected entry per strobe cycle.
    always @(negedge CLK) begin
        evt_t ev;
        if (RST === 1'b0 && (CHANGE_VLD === 1'b1 || VIOLATION === 1'b1 || REJECT === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got vld=%0b viol=%0b rej=%0b change=%0d expected none at %0t",
                         CHANGE_VLD, VIOLATION, REJECT, CHANGE, $time);
            end else begin
                ev = exp_q.pop_front();
                check("change_vld", CHANGE_VLD, ev.vld);
                if (ev.vld) check("change", CHANGE, ev.change);
                check("violation", VIOLATION, ev.viol);
                check("reject", REJECT, ev.rej);
                check("revenue", REVENUE, ev.rev);
            end
        end
    end

    // Hold the car at a closed-out booth (OPEN or FAULT), feeding coins that
    // must all come back as rejects.
    task automatic stay(input int n_coins);
        for (int i = 0; i < n_coins; i++) begin
            if ($urandom_range(0, 1) == 1) step();
            COIN = 1'b1; COIN_VAL = 2'($urandom_range(0, 3));
            expect_reject();
            step();
        end
        // Rate inputs are don't-care outside IDLE.
        H = 1'($urandom); M = 1'($urandom); L = 1'($urandom); E = 1'($urandom);
    endtask

    task automatic run_vehicle(input bit h_i, input bit m_i, input bit l_i, input bit e_i,
                               input int idle_coins, input int leave_at, input bit leave_coin,
                               input int timeout_at, input int extra_coins);
        int fee, credit, nxt, v, code;
        bit fault, paid;
        CAR = 1'b0; H = h_i; M = m_i; L = l_i; E = e_i;
        step();
        for (int i = 0; i < idle_coins; i++) begin
            COIN = 1'b1; COIN_VAL = 2'($urandom_range(0, 3));
            expect_reject();
            step();
        end
        fault = e_i || !(h_i || m_i || l_i);
        fee   = h_i ? FEE_H : (m_i ? FEE_M : FEE_L);
        CAR = 1'b1;
        step();
        check("busy_on_arrival", BUSY, 1);
        check("alarm_on_arrival", ALARM, int'(fault));
        check("gate_on_arrival", GATE_OPEN, 0);
        // Scramble rate inputs: the fee is already latched.
        H = 1'($urandom); M = 1'($urandom); L = 1'($urandom); E = 1'($urandom);
        if (fault) begin
            stay(extra_coins);
            CAR = 1'b0;
            step();
            check("alarm_after_leave", ALARM, 0);
            check("busy_after_leave", BUSY, 0);
            return;
        end
        credit = 0;
        paid   = 1'b0;
        for (int k = 0; k < coin_q.size(); k++) begin
            if (k == timeout_at) begin
                expect_settle(1'b1, credit, 1'b0);
                repeat (TIMEOUT) step();
                check("alarm_on_timeout", ALARM, 1);
                check("gate_on_timeout", GATE_OPEN, 0);
                stay(extra_coins);
                CAR = 1'b0;
                step();
                check("alarm_after_timeout_leave", ALARM, 0);
                check("busy_after_timeout_leave", BUSY, 0);
                return;
            end
            repeat (gap_q[k]) step();
            code = coin_q[k];
            v    = cents(code);
            if (k == leave_at) begin
                CAR = 1'b0;
                if (leave_coin) begin
                    COIN = 1'b1; COIN_VAL = 2'(code);
                    expect_settle(1'b1, sat(credit + v, 255), 1'b0);
                end else begin
                    expect_settle(1'b1, credit, 1'b0);
                end
                step();
                check("busy_after_runaway", BUSY, 0);
                return;
            end
            COIN = 1'b1; COIN_VAL = 2'(code);
            nxt = sat(credit + v, 255);
            if (nxt >= fee) begin
                model_rev = sat(model_rev + fee, 65535);
                expect_settle(1'b0, nxt - fee, 1'b1);
                step();
                check("gate_after_pay", GATE_OPEN, 1);
                check("revenue_after_pay", REVENUE, model_rev);
                paid = 1'b1;
                break;
            end
            credit = nxt;
            step();
        end
        if (!paid) begin
            CAR = 1'b0;
            expect_settle(1'b1, credit, 1'b0);
            step();
            check("busy_after_unpaid", BUSY, 0);
            return;
        end
        stay(extra_coins);
        CAR = 1'b0;
        step();
        check("gate_after_leave", GATE_OPEN, 0);
        check("busy_after_leave", BUSY, 0);
    endtask

    task automatic set_coins2(input int c0, input int g0, input int c1, input int g1);
        coin_q.delete(); gap_q.delete();
        coin_q.push_back(c0); gap_q.push_back(g0);
        coin_q.push_back(c1); gap_q.push_back(g1);
    endtask

    task automatic random_vehicle();
        bit h, m, l, e;
        int fee, sum, code, r, leave_at, timeout_at;
        e = ($urandom_range(0, 9) == 0);
        h = 1'($urandom); m = 1'($urandom); l = 1'($urandom);
        fee = h ? FEE_H : (m ? FEE_M : FEE_L);
        coin_q.delete(); gap_q.delete();
        sum = 0;
        while (sum < fee) begin
            code = $urandom_range(0, 3);
            coin_q.push_back(code);
            gap_q.push_back($urandom_range(0, 4));
            sum += cents(code);
        end
        leave_at = -1; timeout_at = -1;
        r = $urandom_range(0, 9);
        if (r == 0)      timeout_at = $urandom_range(0, coin_q.size() - 1);
        else if (r <= 2) leave_at   = $urandom_range(0, coin_q.size() - 1);
        run_vehicle(h, m, l, e, $urandom_range(0, 1), leave_at, 1'($urandom),
                    timeout_at, $urandom_range(0, 2));
    endtask

    initial begin
        RST = 1'b1; H = 0; M = 0; L = 0; E = 0; CAR = 0; COIN = 0; COIN_VAL = 0;
        step(); step();
        check("rst_busy", BUSY, 0);
        check("rst_gate", GATE_OPEN, 0);
        check("rst_alarm", ALARM, 0);
        check("rst_change", CHANGE, 0);
        check("rst_revenue", REVENUE, 0);
        RST = 1'b0;

        // High rate, 25+25+100 -> change 50, revenue 100.
        set_coins2(2, 0, 2, 1);
        coin_q.push_back(3); gap_q.push_back(0);
        run_vehicle(1, 0, 0, 0, 0, -1, 0, -1, 0);
        // Low rate, exact 25 -> change 0 strobed; coin in OPEN rejected.
        coin_q.delete(); gap_q.delete();
        coin_q.push_back(2); gap_q.push_back(0);
        run_vehicle(0, 0, 1, 0, 0, -1, 0, -1, 1);
        // E with H -> FAULT.
        run_vehicle(1, 0, 0, 1, 0, -1, 0, -1, 0);
        // Medium, 10 then timeout -> refund 10 + violation + alarm.
        set_coins2(1, 0, 3, 0);
        run_vehicle(0, 1, 0, 0, 0, -1, 0, 1, 0);
        // Medium, 25 then leave with a 10 coin -> refund 35.
        set_coins2(2, 0, 1, 2);
        run_vehicle(0, 1, 0, 0, 0, 1, 1, -1, 0);
        // Coin on the last allowed cycle beats the timeout.
        coin_q.delete(); gap_q.delete();
        coin_q.push_back(3); gap_q.push_back(TIMEOUT - 1);
        run_vehicle(0, 1, 0, 0, 1, -1, 0, -1, 0);

        // Reset mid-COLLECT with 30 credit, car held through reset.
        H = 0; M = 1; L = 0; E = 0; CAR = 0;
        step();
        CAR = 1'b1; step();
        COIN = 1'b1; COIN_VAL = 2'd2; step();
        COIN = 1'b1; COIN_VAL = 2'd0; step();
        RST = 1'b1; step();
        check("midrst_busy", BUSY, 0);
        check("midrst_gate", GATE_OPEN, 0);
        check("midrst_alarm", ALARM, 0);
        check("midrst_change_vld", CHANGE_VLD, 0);
        check("midrst_change", CHANGE, 0);
        check("midrst_violation", VIOLATION, 0);
        check("midrst_reject", REJECT, 0);
        check("midrst_revenue", REVENUE, 0);
        RST = 1'b0; model_rev = 0;
        step();
        check("car_high_at_release_is_arrival", BUSY, 1);
        COIN = 1'b1; COIN_VAL = 2'd3;
        model_rev = FEE_M;
        expect_settle(1'b0, 100 - FEE_M, 1'b1);
        step();
        check("gate_after_reset_pay", GATE_OPEN, 1);
        CAR = 1'b0; step();
        check("gate_after_reset_leave", GATE_OPEN, 0);

        for (int n = 0; n < 40; n++) random_vehicle();

        step(); step();
        check("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
